// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: converts a signed (x, y) pair into atan2(y, x)
// in Q3.15 radians plus the gain-scaled magnitude, one micro-rotation per clock.
module cordic_vector #(
  parameter int ITERATIONS = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] x_in,
  input  logic [17:0] y_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] angle_out,
  output logic [18:0] mag_out
);

  localparam logic signed [17:0] PI   = 18'sd102944;
  localparam logic        [3:0]  LAST = 4'(ITERATIONS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;

  function automatic logic signed [17:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    atan_lut = 18'sd25736;
      4'd1:    atan_lut = 18'sd15193;
      4'd2:    atan_lut = 18'sd8027;
      4'd3:    atan_lut = 18'sd4075;
      4'd4:    atan_lut = 18'sd2045;
      4'd5:    atan_lut = 18'sd1024;
      4'd6:    atan_lut = 18'sd512;
      4'd7:    atan_lut = 18'sd256;
      4'd8:    atan_lut = 18'sd128;
      4'd9:    atan_lut = 18'sd64;
      4'd10:   atan_lut = 18'sd32;
      4'd11:   atan_lut = 18'sd16;
      4'd12:   atan_lut = 18'sd8;
      4'd13:   atan_lut = 18'sd4;
      4'd14:   atan_lut = 18'sd2;
      4'd15:   atan_lut = 18'sd1;
      default: atan_lut = 18'sd0;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic signed [19:0] x_q, x_d, y_q, y_d;
  logic signed [17:0] z_q, z_d;
  logic        [3:0]  count_q, count_d;
  logic               zero_q, zero_d;
  logic        [17:0] angle_q, angle_d;
  logic        [18:0] mag_q, mag_d;
  logic               out_valid_q, out_valid_d;

  logic signed [19:0] x_ext_s, y_ext_s, x_sh_s, y_sh_s, x_nxt_s, y_nxt_s;
  logic signed [17:0] atan_s, z_nxt_s;

  // 20-bit sign extension leaves room to negate -131072 exactly
  assign x_ext_s = $signed({{2{x_in[17]}}, x_in});
  assign y_ext_s = $signed({{2{y_in[17]}}, y_in});
  assign x_sh_s  = x_q >>> count_q;
  assign y_sh_s  = y_q >>> count_q;
  assign atan_s  = atan_lut(count_q);

  always_comb begin
    x_nxt_s = x_q;
    y_nxt_s = y_q;
    z_nxt_s = z_q;
    if (!y_q[19]) begin
      x_nxt_s = x_q + y_sh_s;
      y_nxt_s = y_q - x_sh_s;
      z_nxt_s = z_q + atan_s;
    end else begin
      x_nxt_s = x_q - y_sh_s;
      y_nxt_s = y_q + x_sh_s;
      z_nxt_s = z_q - atan_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    count_d     = count_q;
    zero_d      = zero_q;
    angle_d     = angle_q;
    mag_d       = mag_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          count_d = 4'd0;
          zero_d  = (x_in == 18'd0) && (y_in == 18'd0);
          state_d = ITER;
          if (x_in[17]) begin
            x_d = -x_ext_s;
            y_d = -y_ext_s;
            z_d = y_in[17] ? -PI : PI;
          end else begin
            x_d = x_ext_s;
            y_d = y_ext_s;
            z_d = 18'sd0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ITER: begin
        x_d     = x_nxt_s;
        y_d     = y_nxt_s;
        z_d     = z_nxt_s;
        count_d = count_q + 4'd1;
        if (count_q == LAST) begin
          // a zero vector has no defined phase, so z is discarded
          angle_d     = zero_q ? 18'd0 : z_nxt_s;
          mag_d       = x_nxt_s[18:0];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = ITER;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      x_q         <= 20'sd0;
      y_q         <= 20'sd0;
      z_q         <= 18'sd0;
      count_q     <= 4'd0;
      zero_q      <= 1'b0;
      angle_q     <= 18'd0;
      mag_q       <= 19'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      count_q     <= count_d;
      zero_q      <= zero_d;
      angle_q     <= angle_d;
      mag_q       <= mag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign angle_out = angle_q;
  assign mag_out   = mag_q;

endmodule

// File: tb/tb_cordic_vector.sv
// Directed-vector bench for cordic_vector: bit-exact integer reference plus
// real-valued atan2/hypot sanity limits, backpressure and mid-flight reset.
module tb_cordic_vector;

  localparam int PI_Q = 102944;

  typedef struct {
    int x;
    int y;
    int ang;
    int ang_tol;
    int mag;
    int mag_tol;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [17:0] x_in = 18'd0, y_in = 18'd0, angle_out;
  logic [18:0] mag_out;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
  logic        in_ready8, out_valid8;
  logic [17:0] x8 = 18'd0, y8 = 18'd0, angle8;
  logic [18:0] mag8;

  int n_tests = 0;
  int n_fail  = 0;
  int atan_tab [16] = '{25736, 15193, 8027, 4075, 2045, 1024, 512, 256,
                        128, 64, 32, 16, 8, 4, 2, 1};

  cordic_vector dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .angle_out(angle_out), .mag_out(mag_out)
  );

  cordic_vector #(.ITERATIONS(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .x_in(x8), .y_in(y8), .out_valid(out_valid8), .out_ready(out_ready8),
    .angle_out(angle8), .mag_out(mag8)
  );

  always #5 clock = ~clock;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int wrap_diff(input int d);
    if (d > PI_Q) return d - 2 * PI_Q;
    else if (d < -PI_Q) return d + 2 * PI_Q;
    else return d;
  endfunction

  // Integer reference of the vectoring algorithm as defined for the block
  task automatic model(input int xi, input int yi, input int n, output int ang, output int mag);
    int x, y, z, xs, ys;
    if (xi < 0) begin
      x = -xi; y = -yi; z = (yi >= 0) ? PI_Q : -PI_Q;
    end else begin
      x = xi; y = yi; z = 0;
    end
    for (int i = 0; i < n; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (y >= 0) begin
        x = x + ys; y = y - xs; z = z + atan_tab[i];
      end else begin
        x = x - ys; y = y + xs; z = z - atan_tab[i];
      end
    end
    ang = (xi == 0 && yi == 0) ? 0 : z;
    mag = x & 32'h7FFFF;
  endtask

  task automatic check(input bit ok, input string name, input int got, input int exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Send one vector with out_ready=1; checks handshake, latency and exact result
  task automatic run_vec(input int xv, input int yv, output int ang, output int mag);
    int lat, eang, emag;
    bit seen, busy_ok;
    @(negedge clock);
    check(in_ready == 1'b1, "ready_before", int'(in_ready), 1);
    x_in = 18'(xv); y_in = 18'(yv); in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0; seen = 1'b0; busy_ok = 1'b1;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clock); #1;
      lat++;
      if (out_valid) seen = 1'b1;
    end
    if (in_ready) busy_ok = 1'b0;
    check(busy_ok, "in_ready_low_busy", int'(busy_ok), 1);
    check(seen && lat == 16, "latency", lat, 16);
    ang = int'($signed(angle_out));
    mag = int'(mag_out);
    model(xv, yv, 16, eang, emag);
    check(ang == eang, "angle_exact", ang, eang);
    check(mag == emag, "mag_exact", mag, emag);
    @(posedge clock); #1;
    check(!out_valid && in_ready, "done_exit", int'({out_valid, in_ready}), 1);
  endtask

  initial begin
    vec_t vecs [8];
    int ang, mag, a0, m0, eang, emag, xv, yv, lat, bad;
    real rang, rmag;
    bit seen;

    vecs[0] = '{1000, 0, 0, 64, 1647, 12};
    vecs[1] = '{0, 1000, 51472, 64, 1647, 12};
    vecs[2] = '{-1000, 0, 102944, 64, 1647, 12};
    vecs[3] = '{0, 0, 0, 0, 0, 0};
    vecs[4] = '{-1000, -1000, -77208, 64, 2329, 12};
    vecs[5] = '{-131072, 0, 102944, 64, 215845, 40};
    vecs[6] = '{0, -1000, -51472, 64, 1647, 12};
    vecs[7] = '{1000, 1000, 25736, 64, 2329, 12};

    repeat (3) @(posedge clock);
    #1;
    check(in_ready == 1'b1, "rst_in_ready", int'(in_ready), 1);
    check(!out_valid && angle_out == 18'd0 && mag_out == 19'd0, "rst_outputs",
          int'(angle_out) + int'(mag_out) + int'(out_valid), 0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      run_vec(vecs[k].x, vecs[k].y, ang, mag);
      check(iabs(ang - vecs[k].ang) <= vecs[k].ang_tol, "angle_table", ang, vecs[k].ang);
      check(iabs(mag - vecs[k].mag) <= vecs[k].mag_tol, "mag_table", mag, vecs[k].mag);
      if (vecs[k].x < 0 && vecs[k].y == 0) check(ang > 0, "neg_axis_sign", ang, PI_Q);
    end

    // Backpressure: hold result for 10 cycles, then release and go back-to-back
    out_ready = 1'b0;
    @(negedge clock);
    x_in = 18'(3000); y_in = 18'(-2000); in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1'b1;
    end
    check(seen, "bp_out_valid", int'(seen), 1);
    a0 = int'($signed(angle_out));
    m0 = int'(mag_out);
    model(3000, -2000, 16, eang, emag);
    check(a0 == eang && m0 == emag, "bp_result", a0, eang);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      if (!out_valid || in_ready || int'($signed(angle_out)) != a0 || int'(mag_out) != m0) bad++;
    end
    check(bad == 0, "bp_hold", bad, 0);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    check(!out_valid && in_ready, "bp_release", int'({out_valid, in_ready}), 1);
    run_vec(-5000, 7000, ang, mag);

    // Reset while at iteration 7
    @(negedge clock);
    x_in = 18'(20000); y_in = 18'(15000); in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check(!out_valid && in_ready && angle_out == 18'd0 && mag_out == 19'd0, "mid_reset",
          int'(out_valid) + int'(mag_out), 0);
    @(negedge clock);
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      if (out_valid) bad++;
    end
    check(bad == 0, "no_valid_after_reset", bad, 0);
    run_vec(20000, 15000, ang, mag);

    // Random sweep against the exact model and a real-valued atan2/hypot
    for (int n = 0; n < 1000; n++) begin
      xv = int'($urandom_range(262143, 0)) - 131072;
      yv = int'($urandom_range(262143, 0)) - 131072;
      run_vec(xv, yv, ang, mag);
      if (iabs(xv) >= 16384 || iabs(yv) >= 16384) begin
        rang = $atan2(real'(yv), real'(xv)) * 32768.0;
        rmag = 1.6467602581 * $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
        check(iabs(wrap_diff(ang - int'(rang))) <= 96, "sweep_angle", ang, int'(rang));
        check(iabs(mag - int'(rmag)) <= int'(rmag) / 500 + 24, "sweep_mag", mag, int'(rmag));
      end
    end

    // Eight-iteration build: latency and coarser precision
    @(negedge clock);
    x8 = 18'(-20000); y8 = 18'(5000); in_valid8 = 1'b1;
    @(posedge clock); #1;
    in_valid8 = 1'b0;
    lat = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clock); #1;
      lat++;
      if (out_valid8) seen = 1'b1;
    end
    check(seen && lat == 8, "it8_latency", lat, 8);
    model(-20000, 5000, 8, eang, emag);
    ang = int'($signed(angle8));
    check(ang == eang && int'(mag8) == emag, "it8_exact", ang, eang);
    rang = $atan2(5000.0, -20000.0) * 32768.0;
    check(iabs(wrap_diff(ang - int'(rang))) <= 264, "it8_angle", ang, int'(rang));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
